// File: rtl/irq_pending.sv
// Request capture stage ahead of the 8-to-3 priority encoder: synchronizes request lines,
// latches rising edges into sticky pending bits, masks them, and clears one bit per ack.
module irq_pending #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req_in,
   input  logic       mask_we,
   input  logic [7:0] mask_din,
   input  logic       ack,
   input  logic [2:0] ack_code,
   output logic [7:0] pend,
   output logic [7:0] raw_pend,
   output logic [7:0] overrun,
   output logic       irq
);

   logic [7:0] sync_q [SYNC_STAGES];
   logic [7:0] prev_q;
   logic [7:0] raw_q, raw_d;
   logic [7:0] ovr_q, ovr_d;
   logic [7:0] mask_q, mask_d;
   logic [7:0] rise;
   logic [7:0] clr;

   assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign clr  = ack ? (8'b1 << ack_code) : 8'b0;

   // A fresh edge always wins; if it coincides with its own ack it is a new request, not an overrun.
   always_comb begin
      raw_d  = raw_q;
      ovr_d  = ovr_q;
      mask_d = mask_we ? mask_din : mask_q;
      for (int i = 0; i < 8; i++) begin
         if (rise[i]) begin
            raw_d[i] = 1'b1;
            if (clr[i]) begin
               ovr_d[i] = 1'b0;
            end else if (raw_q[i]) begin
               ovr_d[i] = 1'b1;
            end
         end else if (clr[i]) begin
            raw_d[i] = 1'b0;
            ovr_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '{default: '0};
         prev_q <= '0;
         raw_q  <= '0;
         ovr_q  <= '0;
         mask_q <= 8'hff;
      end else begin
         sync_q[0] <= req_in;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
         prev_q <= sync_q[SYNC_STAGES-1];
         raw_q  <= raw_d;
         ovr_q  <= ovr_d;
         mask_q <= mask_d;
      end
   end

   assign raw_pend = raw_q;
   assign overrun  = ovr_q;
   assign pend     = raw_q & mask_q;
   assign irq      = |pend;

endmodule
